// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, write-arbiter state encoding
// and the write-request record used by the write-port arbiter.
package regfile_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        FORCE_LU = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, LU is forced after
// STARVE_MAX denied cycles. Optional RF_WR_BYPASS_EN adds a write-to-read bypass.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int DATA_W     = RF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef RF_WR_BYPASS_EN
    input  logic [ADDR_W-1:0] rd_addr_rs1,
    input  logic [ADDR_W-1:0] rd_addr_rs2,
    output logic              byp_hit_rs1,
    output logic              byp_hit_rs2,
    output logic [DATA_W-1:0] byp_data,
`endif
    output logic              lu_starved
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              wb_xfer, lu_xfer;

    // Grants depend only on state and valids, never on addr/data.
    always_comb begin
        wb_ready = 1'b0;
        lu_ready = 1'b0;
        case (state_q)
            NORMAL: begin
                wb_ready = wb_valid;
                lu_ready = lu_valid && !wb_valid;
            end
            FORCE_LU: begin
                lu_ready = lu_valid;
            end
            default: begin
                wb_ready = 1'b0;
                lu_ready = 1'b0;
            end
        endcase
    end

    assign wb_xfer = wb_valid && wb_ready;
    assign lu_xfer = lu_valid && lu_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (!lu_valid || lu_xfer) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FORCE_LU lasts exactly one cycle: LU either transfers or has withdrawn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:   if (cnt_d == CNT_MAX) state_d = FORCE_LU;
            FORCE_LU: if (!lu_valid || lu_xfer) state_d = NORMAL;
            default:  state_d = NORMAL;
        endcase
    end

    // x0 writes complete the handshake and load the registers, but never assert we.
    always_comb begin
        rf_we_d    = (wb_xfer && (wb_addr != '0)) || (lu_xfer && (lu_addr != '0));
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_xfer) begin
            rf_waddr_d = wb_addr;
            rf_wdata_d = wb_data;
        end else if (lu_xfer) begin
            rf_waddr_d = lu_addr;
            rf_wdata_d = lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NORMAL;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign lu_starved = (state_q == FORCE_LU);

`ifdef RF_WR_BYPASS_EN
    // Covers the cycle before the register file has captured the pending write.
    assign byp_hit_rs1 = rf_we_q && (rf_waddr_q == rd_addr_rs1) && (rd_addr_rs1 != '0);
    assign byp_hit_rs2 = rf_we_q && (rf_waddr_q == rd_addr_rs2) && (rd_addr_rs2 != '0);
    assign byp_data    = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a
// randomized run against a wait-count reference model.
module tb_regfile_wr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_valid = 1'b0, lu_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0, lu_addr = '0;
    logic [DW-1:0] wb_data = '0, lu_data = '0;
    logic          wb_ready, lu_ready, rf_we, lu_starved;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef RF_WR_BYPASS_EN
    logic [AW-1:0] rd_addr_rs1 = '0, rd_addr_rs2 = '0;
    logic          byp_hit_rs1, byp_hit_rs2;
    logic [DW-1:0] byp_data;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: LU wait count; LU is forced once it has waited SMAX cycles.
    int            m_wait;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          e_wb_ready, e_lu_ready, e_starved;
    logic          wb_acc_prev, lu_acc_prev;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_addr    (lu_addr),
        .lu_data    (lu_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
`ifdef RF_WR_BYPASS_EN
        .rd_addr_rs1(rd_addr_rs1),
        .rd_addr_rs2(rd_addr_rs2),
        .byp_hit_rs1(byp_hit_rs1),
        .byp_hit_rs2(byp_hit_rs2),
        .byp_data   (byp_data),
`endif
        .lu_starved (lu_starved)
    );

    task automatic model_reset();
        m_wait = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        wb_acc_prev = 1'b1; lu_acc_prev = 1'b1;
    endtask

    task automatic model_predict();
        e_starved = (m_wait == SMAX);
        if (e_starved) begin
            e_wb_ready = 1'b0;
            e_lu_ready = lu_valid;
        end else begin
            e_wb_ready = wb_valid;
            e_lu_ready = lu_valid && !wb_valid;
        end
    endtask

    task automatic model_commit();
        logic wbx, lux;
        wbx = wb_valid && e_wb_ready;
        lux = lu_valid && e_lu_ready;
        m_we = (wbx && wb_addr != 0) || (lux && lu_addr != 0);
        if (wbx) begin m_waddr = wb_addr; m_wdata = wb_data; end
        else if (lux) begin m_waddr = lu_addr; m_wdata = lu_data; end
        if (lu_valid && !lux) m_wait = (m_wait + 1 > SMAX) ? SMAX : m_wait + 1;
        else m_wait = 0;
        wb_acc_prev = wbx || !wb_valid;
        lu_acc_prev = lux || !lu_valid;
    endtask

    // Leaves time at a falling edge with reset released and inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        wb_valid = 1'b0; lu_valid = 1'b0;
        wb_addr = '0; lu_addr = '0; wb_data = '0; lu_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_waddr !== '0) begin errors++; $display("FAIL reset_rf_waddr got=%0h exp=0", rf_waddr); end
        checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL reset_rf_wdata got=%0h exp=0", rf_wdata); end
        checks++; if (lu_starved !== 1'b0) begin errors++; $display("FAIL reset_lu_starved got=%b exp=0", lu_starved); end
        do_reset();
        #2;
        checks++; if (wb_ready !== 1'b0 || lu_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready got=%b%b exp=00", wb_ready, lu_ready); end
        $display("test_reset done");
    endtask

    task automatic test_wb_single();
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'd124;
        #2;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb1_ready got=%b exp=1", wb_ready); end
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL wb1_lu_ready got=%b exp=0", lu_ready); end
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0;
        #2;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL wb1_rf_we got=%b exp=1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL wb1_rf_waddr got=%0d exp=5", rf_waddr); end
        checks++; if (rf_wdata !== 32'd124) begin errors++; $display("FAIL wb1_rf_wdata got=%0d exp=124", rf_wdata); end
        @(posedge clk); @(negedge clk);
        #2;
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5) begin errors++; $display("FAIL wb1_hold got we=%b addr=%0d exp we=0 addr=5", rf_we, rf_waddr); end
        $display("txn WB x5=124 done");
    endtask

    task automatic test_starvation();
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd3;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hABCD;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) begin lu_addr = 5'd9; lu_data = 32'h1234; end
            wb_data = 32'(c * 16);
            #2;
            checks++; if (wb_ready !== (c != 5)) begin errors++; $display("FAIL starve_wb_ready c=%0d got=%b exp=%b", c, wb_ready, c != 5); end
            checks++; if (lu_ready !== (c == 5)) begin errors++; $display("FAIL starve_lu_ready c=%0d got=%b exp=%b", c, lu_ready, c == 5); end
            checks++; if (lu_starved !== (c == 5)) begin errors++; $display("FAIL starve_flag c=%0d got=%b exp=%b", c, lu_starved, c == 5); end
            if (c >= 2) begin
                checks++; if (rf_we !== 1'b1 || rf_waddr !== ((c == 6) ? 5'd7 : 5'd3)) begin errors++; $display("FAIL starve_rf c=%0d got we=%b addr=%0d", c, rf_we, rf_waddr); end
                checks++; if (rf_wdata !== ((c == 6) ? 32'hABCD : 32'((c - 1) * 16))) begin errors++; $display("FAIL starve_wdata c=%0d got=%0h", c, rf_wdata); end
            end
            @(posedge clk); @(negedge clk);
        end
        $display("txn starvation sequence done");
    endtask

    task automatic test_x0_write();
        do_reset();
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hFFFF_FFFF;
        #2;
        checks++; if (lu_ready !== 1'b1 || wb_ready !== 1'b0) begin errors++; $display("FAIL x0_ready got lu=%b wb=%b exp lu=1 wb=0", lu_ready, wb_ready); end
        @(posedge clk); @(negedge clk);
        lu_valid = 1'b0;
        #2;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL x0_regs got addr=%0d data=%0h exp 0/ffffffff", rf_waddr, rf_wdata); end
        $display("txn LU x0 done");
    endtask

    task automatic test_reset_in_force();
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
        lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'h88;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        #2;
        checks++; if (lu_starved !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL rstf_pre got starved=%b we=%b exp 1/1", lu_starved, rf_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || lu_starved !== 1'b0) begin errors++; $display("FAIL rstf_async got we=%b starved=%b exp 0/0", rf_we, lu_starved); end
        checks++; if (rf_waddr !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL rstf_regs got addr=%0d data=%0h exp 0/0", rf_waddr, rf_wdata); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #2;
            checks++; if (lu_ready !== (c == 5) || wb_ready !== (c != 5)) begin errors++; $display("FAIL rstf_rearb c=%0d got lu=%b wb=%b", c, lu_ready, wb_ready); end
            @(posedge clk); @(negedge clk);
        end
        $display("txn reset during FORCE_LU done");
    endtask

    task automatic test_lu_drop();
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        lu_valid = 1'b0;
        #2;
        checks++; if (lu_starved !== 1'b1 || wb_ready !== 1'b0) begin errors++; $display("FAIL drop_force got starved=%b wb=%b exp 1/0", lu_starved, wb_ready); end
        @(posedge clk); @(negedge clk);
        lu_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #2;
            checks++; if (lu_starved !== (c == 5) || wb_ready !== (c != 5)) begin errors++; $display("FAIL drop_after c=%0d got starved=%b wb=%b", c, lu_starved, wb_ready); end
            @(posedge clk); @(negedge clk);
        end
        $display("txn LU drop in FORCE_LU done");
    endtask

`ifdef RF_WR_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'd214;
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0; rd_addr_rs1 = 5'd10; rd_addr_rs2 = 5'd0;
        #2;
        checks++; if (byp_hit_rs1 !== 1'b1 || byp_data !== 32'd214) begin errors++; $display("FAIL byp_rs1 got hit=%b data=%0d exp 1/214", byp_hit_rs1, byp_data); end
        checks++; if (byp_hit_rs2 !== 1'b0) begin errors++; $display("FAIL byp_rs2_x0 got=%b exp=0", byp_hit_rs2); end
        @(posedge clk); @(negedge clk);
        #2;
        checks++; if (byp_hit_rs1 !== 1'b0) begin errors++; $display("FAIL byp_no_we got=%b exp=0", byp_hit_rs1); end
        $display("txn bypass x10=214 done");
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (wb_acc_prev) begin
                wb_valid = ($urandom_range(0, 99) < 60);
                wb_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb_data  = $urandom;
            end
            if (lu_acc_prev) begin
                lu_valid = ($urandom_range(0, 99) < 50);
                lu_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                lu_data  = $urandom;
            end
            model_predict();
            #2;
            checks++; if (wb_ready !== e_wb_ready) begin errors++; $display("FAIL rnd_wb_ready c=%0d got=%b exp=%b", c, wb_ready, e_wb_ready); end
            checks++; if (lu_ready !== e_lu_ready) begin errors++; $display("FAIL rnd_lu_ready c=%0d got=%b exp=%b", c, lu_ready, e_lu_ready); end
            checks++; if (lu_starved !== e_starved) begin errors++; $display("FAIL rnd_starved c=%0d got=%b exp=%b", c, lu_starved, e_starved); end
            checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_rf_we c=%0d got=%b exp=%b", c, rf_we, m_we); end
            checks++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin errors++; $display("FAIL rnd_rf c=%0d got %0d/%0h exp %0d/%0h", c, rf_waddr, rf_wdata, m_waddr, m_wdata); end
            if (wb_valid && e_wb_ready) $display("txn c=%0d WB x%0d=%h", c, wb_addr, wb_data);
            if (lu_valid && e_lu_ready) $display("txn c=%0d LU x%0d=%h", c, lu_addr, lu_data);
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_wb_single();
        test_starvation();
        test_x0_write();
        test_reset_in_force();
        test_lu_drop();
`ifdef RF_WR_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
